// File: rtl/cpu_pkg.sv
// Shared definitions for the Hack-style CPU controller: FSM states,
// datapath width and instruction field bit positions.
package cpu_pkg;

    localparam int WIDTH = 16;

    // C-instruction layout: 1 x x a c1..c6 d1 d2 d3 j1 j2 j3
    localparam int CBIT    = 15;
    localparam int ABIT    = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JMP_LT  = 2;
    localparam int JMP_EQ  = 1;
    localparam int JMP_GT  = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MEM_RD,
        EXEC,
        MEM_WR,
        COMMIT
    } state_t;

endpackage

// File: rtl/cpu_jump_cond.sv
// Jump decision from the j field and the latched ALU zero/negative flags.
module cpu_jump_cond
    import cpu_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    assign take = (j[JMP_LT] & ng) | (j[JMP_EQ] & zr) | (j[JMP_GT] & ~ng & ~zr);

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit Hack-style CPU.
// Owns A, D and PC, drives the external ALU and both memory handshakes.
module cpu_control #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_valid,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ready,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] d_reg
);
    import cpu_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] r_reg;
    logic             zr_flag;
    logic             ng_flag;
    logic             take;
    logic [2:0]       jump_bits;
    logic [5:0]       comp;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc     = pc + WIDTH'(1);
    assign jump_bits  = {ir[JMP_LT], ir[JMP_EQ], ir[JMP_GT]};
    assign imem_addr  = pc;
    assign dmem_addr  = a_reg;
    assign dmem_wdata = r_reg;
    assign alu_x      = d_reg;
    assign alu_y      = ir[ABIT] ? m_reg : a_reg;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = comp;

    cpu_jump_cond u_jump_cond (
        .j    (jump_bits),
        .zr   (zr_flag),
        .ng   (ng_flag),
        .take (take)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_valid) state_next = DECODE;
            DECODE: begin
                if (!ir[CBIT])     state_next = FETCH;
                else if (ir[ABIT]) state_next = MEM_RD;
                else               state_next = EXEC;
            end
            MEM_RD:  if (dmem_ready) state_next = EXEC;
            EXEC:    state_next = ir[DEST_M] ? MEM_WR : COMMIT;
            MEM_WR:  if (dmem_ready) state_next = COMMIT;
            COMMIT:  state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Requests are masked while reset is asserted so nothing is issued before
    // the first cycle after release, even though the state is already FETCH.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        comp     = '0;
        if (!reset) begin
            case (state)
                FETCH:   imem_req = 1'b1;
                MEM_RD:  dmem_req = 1'b1;
                MEM_WR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                end
                default: ;
            endcase
            if (ir[CBIT]) comp = ir[COMP_HI:COMP_LO];
        end
    end

    // COMMIT reads the pre-instruction A for the jump target while A itself
    // may be overwritten by R in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            a_reg   <= '0;
            d_reg   <= '0;
            ir      <= '0;
            m_reg   <= '0;
            r_reg   <= '0;
            zr_flag <= 1'b0;
            ng_flag <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (imem_valid) ir <= imem_rdata;
                DECODE: begin
                    if (!ir[CBIT]) begin
                        a_reg <= {1'b0, ir[CBIT-1:0]};
                        pc    <= pc_inc;
                    end
                end
                MEM_RD: if (dmem_ready) m_reg <= dmem_rdata;
                EXEC: begin
                    r_reg   <= alu_out;
                    zr_flag <= alu_zr;
                    ng_flag <= alu_ng;
                end
                COMMIT: begin
                    if (ir[DEST_A]) a_reg <= r_reg;
                    if (ir[DEST_D]) d_reg <= r_reg;
                    pc <= take ? a_reg : pc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: ISA-level reference model plus a
// scoreboard of expected data-memory stores.
module tb_cpu_control;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ready;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;
    logic [15:0] pc, a_reg, d_reg;

    logic [15:0] imem [0:255];
    logic        imem_en = 1'b0;
    logic        dmem_en = 1'b0;
    logic        dmem_force = 1'b0;
    logic [15:0] dmem_load = 16'h0000;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_a, m_d, m_pc;
    wr_t         exp_wr_q[$];
    wr_t         obs_wr_q[$];
    logic [5:0]  snap_ctrl [0:63];
    logic [15:0] snap_x [0:63];
    logic [15:0] snap_y [0:63];
    int          req_cycles;

    always #5 clk = ~clk;

    function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return {(o == 16'h0000), o[15], o};
    endfunction

    assign imem_rdata = imem[imem_addr[7:0]];
    assign imem_valid = imem_req & imem_en;
    assign dmem_rdata = dmem_load;
    assign dmem_ready = (dmem_req & dmem_en) | dmem_force;
    assign {alu_zr, alu_ng, alu_out} =
        hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});

    cpu_control #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
    );

    // Every completed store (request, write enable and acknowledge together).
    always @(negedge clk) begin
        if (!reset && dmem_req && dmem_we && dmem_ready)
            obs_wr_q.push_back({dmem_addr, dmem_wdata});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // ISA-level model of one instruction; queues the store it should make.
    task automatic model_step(input logic [15:0] ins);
        logic [15:0] y, res;
        logic        zr, ng, jmp;
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = m_pc + 16'd1;
        end else begin
            y = ins[12] ? dmem_load : m_a;
            {zr, ng, res} = hack_alu(m_d, y, ins[11:6]);
            if (ins[3]) exp_wr_q.push_back({m_a, res});
            jmp  = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~ng & ~zr);
            m_pc = jmp ? m_a : m_pc + 16'd1;
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
        end
    endtask

    // Called at a negedge with the DUT stalled in FETCH; returns when it is
    // back in FETCH. dly = wait cycles before each data acknowledge.
    task automatic run_instr(input logic [15:0] ins, input int dly, output int cycles);
        int wait_cnt;
        wait_cnt = 0;
        imem[m_pc[7:0]] = ins;
        model_step(ins);
        imem_en    = 1'b1;
        cycles     = 0;
        req_cycles = 0;
        do begin
            if (dmem_req) begin
                dmem_en = (wait_cnt >= dly);
                wait_cnt++;
                req_cycles++;
            end else begin
                dmem_en  = 1'b0;
                wait_cnt = 0;
            end
            snap_ctrl[cycles] = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
            snap_x[cycles]    = alu_x;
            snap_y[cycles]    = alu_y;
            cycles++;
            @(negedge clk);
            imem_en = 1'b0;
        end while (!imem_req && cycles < 40);
        dmem_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_imem_req: got %b expected 0", imem_req); end
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_dmem_req: got %b expected 0", dmem_req); end
        checks++; if (pc !== 16'h0000) begin failures++; $display("[TB] FAIL reset_pc: got %h expected 0000", pc); end
        checks++; if (a_reg !== 16'h0000 || d_reg !== 16'h0000) begin failures++; $display("[TB] FAIL reset_ad: got a=%h d=%h expected 0000/0000", a_reg, d_reg); end
        checks++; if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b000000) begin failures++; $display("[TB] FAIL reset_alu_ctrl: got %b expected 000000", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL first_cycle_imem_req: got %b expected 1", imem_req); end
        m_a = 16'h0000; m_d = 16'h0000; m_pc = 16'h0000;
        @(negedge clk);
    endtask

    task automatic test_a_then_c();
        int cyc;
        run_instr(16'h0005, 0, cyc);
        checks++; if (cyc !== 2) begin failures++; $display("[TB] FAIL a_instr_cycles: got %0d expected 2", cyc); end
        checks++; if (a_reg !== 16'd5) begin failures++; $display("[TB] FAIL a_instr_a: got %h expected 0005", a_reg); end
        run_instr(16'hEC10, 0, cyc);
        checks++; if (cyc !== 4) begin failures++; $display("[TB] FAIL c_instr_cycles: got %0d expected 4", cyc); end
        checks++; if (d_reg !== 16'd5 || a_reg !== 16'd5) begin failures++; $display("[TB] FAIL d_eq_a: got a=%h d=%h expected 0005/0005", a_reg, d_reg); end
        checks++; if (snap_ctrl[2] !== 6'b110000) begin failures++; $display("[TB] FAIL exec_alu_ctrl: got %b expected 110000", snap_ctrl[2]); end
        checks++; if (snap_x[2] !== 16'h0000 || snap_y[2] !== 16'h0005) begin failures++; $display("[TB] FAIL exec_operands: got x=%h y=%h expected 0000/0005", snap_x[2], snap_y[2]); end
        checks++; if (req_cycles !== 0) begin failures++; $display("[TB] FAIL no_dmem_access: got %0d expected 0", req_cycles); end
        checks++; if (pc !== 16'd2) begin failures++; $display("[TB] FAIL pc_after_two: got %h expected 0002", pc); end
    endtask

    task automatic test_store();
        int  cyc;
        wr_t obs, exp;
        obs_wr_q.delete();
        exp_wr_q.delete();
        run_instr(16'h0007, 0, cyc);
        run_instr(16'hEC10, 0, cyc);
        run_instr(16'h0064, 0, cyc);
        run_instr(16'hE7C8, 0, cyc);
        checks++; if (cyc !== 5) begin failures++; $display("[TB] FAIL store_cycles: got %0d expected 5", cyc); end
        checks++; if (req_cycles !== 1) begin failures++; $display("[TB] FAIL store_req_cycles: got %0d expected 1", req_cycles); end
        checks++; if (obs_wr_q.size() !== 1 || exp_wr_q.size() !== 1) begin failures++; $display("[TB] FAIL store_count: got %0d writes expected %0d", obs_wr_q.size(), exp_wr_q.size()); end
        if (obs_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            obs = obs_wr_q.pop_front();
            exp = exp_wr_q.pop_front();
            checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL store_data: got addr=%h data=%h expected addr=%h data=%h", obs.addr, obs.data, exp.addr, exp.data); end
            checks++; if (obs.addr !== 16'd100 || obs.data !== 16'd8) begin failures++; $display("[TB] FAIL store_const: got addr=%h data=%h expected 0064/0008", obs.addr, obs.data); end
        end
        checks++; if (a_reg !== 16'd100 || d_reg !== 16'd7) begin failures++; $display("[TB] FAIL store_ad: got a=%h d=%h expected 0064/0007", a_reg, d_reg); end
        checks++; if (pc !== m_pc) begin failures++; $display("[TB] FAIL store_pc: got %h expected %h", pc, m_pc); end
    endtask

    task automatic test_jump();
        int cyc;
        run_instr(16'h0003, 0, cyc);
        run_instr(16'hEC10, 0, cyc);
        run_instr(16'h0028, 0, cyc);
        run_instr(16'hE301, 0, cyc);
        checks++; if (pc !== 16'd40 || cyc !== 4) begin failures++; $display("[TB] FAIL jgt_taken: got pc=%h cycles=%0d expected 0028/4", pc, cyc); end
        run_instr(16'hEA90, 0, cyc);
        run_instr(16'h0028, 0, cyc);
        run_instr(16'hE301, 0, cyc);
        checks++; if (pc !== 16'd43 || pc !== m_pc) begin failures++; $display("[TB] FAIL jgt_zero: got pc=%h expected %h", pc, m_pc); end
        run_instr(16'hEE90, 0, cyc);
        run_instr(16'h0028, 0, cyc);
        run_instr(16'hE301, 0, cyc);
        checks++; if (pc !== 16'd46 || pc !== m_pc) begin failures++; $display("[TB] FAIL jgt_negative: got pc=%h expected %h", pc, m_pc); end
        run_instr(16'h0028, 0, cyc);
        run_instr(16'hEA87, 0, cyc);
        checks++; if (pc !== 16'd40) begin failures++; $display("[TB] FAIL jmp_always: got pc=%h expected 0028", pc); end
    endtask

    task automatic test_mem_read_stall();
        int cyc;
        dmem_load = 16'h1234;
        obs_wr_q.delete();
        run_instr(16'h0009, 0, cyc);
        run_instr(16'hFC10, 3, cyc);
        checks++; if (cyc !== 8) begin failures++; $display("[TB] FAIL read_cycles: got %0d expected 8", cyc); end
        checks++; if (req_cycles !== 4) begin failures++; $display("[TB] FAIL read_req_held: got %0d expected 4", req_cycles); end
        checks++; if (d_reg !== 16'h1234 || d_reg !== m_d) begin failures++; $display("[TB] FAIL read_d: got %h expected %h", d_reg, m_d); end
        checks++; if (snap_y[6] !== 16'h1234 || snap_ctrl[6] !== 6'b110000) begin failures++; $display("[TB] FAIL read_exec_y: got y=%h ctrl=%b expected 1234/110000", snap_y[6], snap_ctrl[6]); end
        checks++; if (a_reg !== 16'd9 || obs_wr_q.size() !== 0) begin failures++; $display("[TB] FAIL read_side_effects: got a=%h writes=%0d expected 0009/0", a_reg, obs_wr_q.size()); end
    endtask

    task automatic test_pc_wrap();
        int cyc;
        run_instr(16'hEE90, 0, cyc);
        run_instr(16'hE320, 0, cyc);
        checks++; if (a_reg !== 16'hFFFF) begin failures++; $display("[TB] FAIL a_from_d: got %h expected ffff", a_reg); end
        run_instr(16'hEA87, 0, cyc);
        checks++; if (pc !== 16'hFFFF) begin failures++; $display("[TB] FAIL jump_to_top: got %h expected ffff", pc); end
        run_instr(16'h0001, 0, cyc);
        checks++; if (pc !== 16'h0000 || a_reg !== 16'h0001) begin failures++; $display("[TB] FAIL pc_wrap: got pc=%h a=%h expected 0000/0001", pc, a_reg); end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        int n;
        obs_wr_q.delete();
        imem[m_pc[7:0]] = 16'hE7C8;
        imem_en = 1'b1;
        @(negedge clk);
        imem_en = 1'b0;
        n = 0;
        while (!(dmem_req && dmem_we) && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 10) begin failures++; $display("[TB] FAIL reach_mem_wr: got %0d cycles expected <10", n); end
        repeat (2) @(negedge clk);
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("[TB] FAIL write_held: got req=%b we=%b expected 1/1", dmem_req, dmem_we); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_drops_req: got req=%b we=%b expected 0/0", dmem_req, dmem_we); end
        checks++; if (pc !== 16'h0000) begin failures++; $display("[TB] FAIL reset_mid_pc: got %h expected 0000", pc); end
        reset = 1'b0;
        dmem_force = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b1 || pc !== 16'h0000) begin failures++; $display("[TB] FAIL late_ack: got dreq=%b ireq=%b pc=%h expected 0/1/0000", dmem_req, imem_req, pc); end
        checks++; if (obs_wr_q.size() !== 0) begin failures++; $display("[TB] FAIL no_write_after_reset: got %0d writes expected 0", obs_wr_q.size()); end
        dmem_force = 1'b0;
        m_a = 16'h0000; m_d = 16'h0000; m_pc = 16'h0000;
        exp_wr_q.delete();
        run_instr(16'h0005, 0, cyc);
        checks++; if (cyc !== 2 || a_reg !== 16'd5 || pc !== 16'd1) begin failures++; $display("[TB] FAIL resume_after_reset: got cycles=%0d a=%h pc=%h expected 2/0005/0001", cyc, a_reg, pc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        test_reset();
        test_a_then_c();
        test_store();
        test_jump();
        test_mem_read_stall();
        test_pc_wrap();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
